// File: rtl/ifft_pkg.sv
// ifft_pkg: shared constants, types and helpers for the IFFT butterfly feeder stages.
//   FftNDefault   - default transform size
//   TwGuardBits   - integer bits of the twiddle Q-format (Q2.(DATA_W-2))
//   TwLutFracBits - fractional bits held in the twiddle quarter-wave table
//   TwLutMaxN     - largest transform size the twiddle table covers
//   feed_state_e  - feeder FSM state
//   log2_f        - ceil(log2(n)) for elaboration-time sizing
//   tw_frac_bits  - fractional bits of a DATA_W-wide twiddle
package ifft_pkg;

   localparam int unsigned FftNDefault   = 64;
   localparam int unsigned TwGuardBits   = 2;
   localparam int unsigned TwLutFracBits = 14;
   localparam int unsigned TwLutMaxN     = 64;

   typedef enum logic {
      StFill = 1'b0,
      StPair = 1'b1
   } feed_state_e;

   function automatic int unsigned log2_f(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned tw_frac_bits(input int unsigned data_w);
      return data_w - TwGuardBits;
   endfunction

endpackage

// File: rtl/twiddle_rom.sv
// twiddle_rom: combinational IFFT twiddle lookup, W(m) = exp(+j*2*pi*m/FFT_N) in Q2.(DATA_W-2).
//   m_i - twiddle index, 0..FFT_N/2-1
//   w_o - {w_re, w_im}, two's complement, DATA_W bits each
// A 17-entry quarter-wave sine table at 14 fractional bits on a 64-point circle serves every
// FFT_N up to 64; m is stretched onto that circle and the result rescaled to DATA_W-2 bits.
module twiddle_rom
   import ifft_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FFT_N  = FftNDefault,
   parameter int unsigned ADDR_W = 5
) (
   input  logic [ADDR_W-1:0]   m_i,
   output logic [2*DATA_W-1:0] w_o
);

   localparam int unsigned LutLog2N = log2_f(TwLutMaxN);
   localparam int unsigned Log2N    = log2_f(FFT_N);
   localparam int unsigned Stride   = (LutLog2N >= Log2N) ? LutLog2N - Log2N : 0;
   localparam int unsigned FracBits = tw_frac_bits(DATA_W);
   localparam int unsigned ShL = (FracBits >= TwLutFracBits) ? FracBits - TwLutFracBits : 0;
   localparam int unsigned ShR = (FracBits < TwLutFracBits) ? TwLutFracBits - FracBits : 0;
   localparam int          RndBit = (ShR > 0) ? (1 << (ShR - 1)) : 0;

   if (FFT_N > TwLutMaxN || FFT_N < 2) begin : g_bad_size
      $error("twiddle_rom: FFT_N must lie in 2..64");
   end

   // round(sin(2*pi*i/64) * 2^14), i = 0..16
   function automatic int quarter_sin(input logic [4:0] i);
      case (i)
         5'd0:    return 0;
         5'd1:    return 1606;
         5'd2:    return 3196;
         5'd3:    return 4756;
         5'd4:    return 6270;
         5'd5:    return 7723;
         5'd6:    return 9102;
         5'd7:    return 10394;
         5'd8:    return 11585;
         5'd9:    return 12665;
         5'd10:   return 13623;
         5'd11:   return 14449;
         5'd12:   return 15137;
         5'd13:   return 15679;
         5'd14:   return 16069;
         5'd15:   return 16305;
         5'd16:   return 16384;
         default: return 0;
      endcase
   endfunction

   logic [4:0] j;  // angle index on the 64-point circle, 0..31 (upper half-plane)
   int         v_re, v_im, sc_re, sc_im;

   always_comb begin
      j = 5'(32'(m_i) << Stride);
      if (j <= 5'd16) begin
         v_re = quarter_sin(5'd16 - j);
         v_im = quarter_sin(j);
      end else begin
         v_re = -quarter_sin(j - 5'd16);
         v_im = quarter_sin(5'(6'd32 - {1'b0, j}));
      end
      sc_re = ((v_re <<< ShL) + RndBit) >>> ShR;
      sc_im = ((v_im <<< ShL) + RndBit) >>> ShR;
      w_o   = {DATA_W'(sc_re), DATA_W'(sc_im)};
   end

endmodule

// File: rtl/bfly_pair_feeder.sv
// bfly_pair_feeder: operand stage for one radix-2 IFFT butterfly stage.
// Buffers the first D samples of each 2D-sample block, then pairs buffer[k] with the live
// sample k+D and presents both with twiddle W(k << STAGE) to the butterfly.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - sample handshake; in_re/in_im sample
//   out_valid/out_ready - pair handshake; in1_* buffered sample, in2_* live sample
//   w_re/w_im           - twiddle, Q2.(DATA_W-2)
//   out_last            - pair k = D-1 of the block
module bfly_pair_feeder
   import ifft_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FFT_N  = FftNDefault,
   parameter int unsigned STAGE  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_re,
   input  logic [DATA_W-1:0] in_im,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] in1_re,
   output logic [DATA_W-1:0] in1_im,
   output logic [DATA_W-1:0] in2_re,
   output logic [DATA_W-1:0] in2_im,
   output logic [DATA_W-1:0] w_re,
   output logic [DATA_W-1:0] w_im,
   output logic              out_last
);

   localparam int unsigned Log2N = log2_f(FFT_N);
   localparam int unsigned Span  = FFT_N >> (STAGE + 1);
   localparam int unsigned KW    = (log2_f(Span) > 0) ? log2_f(Span) : 1;
   localparam int unsigned AW    = (Log2N > 1) ? Log2N - 1 : 1;
   localparam logic [KW-1:0] KLast = KW'(Span - 1);

   feed_state_e       state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [DATA_W-1:0] in1_re_q, in1_re_d, in1_im_q, in1_im_d;
   logic [DATA_W-1:0] in2_re_q, in2_re_d, in2_im_q, in2_im_d;
   logic [DATA_W-1:0] w_re_q, w_re_d, w_im_q, w_im_d;

   logic [2*DATA_W-1:0] mem_q [Span];
   logic                mem_we;
   logic                accept, k_wrap;
   logic [AW-1:0]       m;
   logic [2*DATA_W-1:0] w;

   // (D-1) << STAGE = FFT_N/2 - 2^STAGE, so the index never needs the mod-FFT_N/2 wrap.
   assign m = AW'(32'(k_q) << STAGE);

   twiddle_rom #(
      .DATA_W(DATA_W),
      .FFT_N (FFT_N),
      .ADDR_W(AW)
   ) u_twiddle_rom (
      .m_i(m),
      .w_o(w)
   );

   // FILL always accepts so the next block can fill while the last pair is stalled.
   assign in_ready = (state_q == StFill) || !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign k_wrap   = (k_q == KLast);

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      in1_re_d    = in1_re_q;
      in1_im_d    = in1_im_q;
      in2_re_d    = in2_re_q;
      in2_im_d    = in2_im_q;
      w_re_d      = w_re_q;
      w_im_d      = w_im_q;
      mem_we      = 1'b0;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (accept) begin
         k_d = k_wrap ? '0 : k_q + KW'(1);
         unique case (state_q)
            StFill: begin
               mem_we = 1'b1;
               if (k_wrap) state_d = StPair;
            end
            StPair: begin
               {in1_re_d, in1_im_d} = mem_q[k_q];
               in2_re_d             = in_re;
               in2_im_d             = in_im;
               {w_re_d, w_im_d}     = w;
               out_last_d           = k_wrap;
               out_valid_d          = 1'b1;
               if (k_wrap) state_d = StFill;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StFill;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         in1_re_q    <= '0;
         in1_im_q    <= '0;
         in2_re_q    <= '0;
         in2_im_q    <= '0;
         w_re_q      <= '0;
         w_im_q      <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         in1_re_q    <= in1_re_d;
         in1_im_q    <= in1_im_d;
         in2_re_q    <= in2_re_d;
         in2_im_q    <= in2_im_d;
         w_re_q      <= w_re_d;
         w_im_q      <= w_im_d;
      end
   end

   // Sample buffer is deliberately not reset; a fresh block always rewrites it before use.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[k_q] <= {in_re, in_im};
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign in1_re    = in1_re_q;
   assign in1_im    = in1_im_q;
   assign in2_re    = in2_re_q;
   assign in2_im    = in2_im_q;
   assign w_re      = w_re_q;
   assign w_im      = w_im_q;

endmodule

// File: tb/tb_bfly_pair_feeder.sv
module tb_bfly_pair_feeder;

   localparam int unsigned DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // A: FFT_N=8 STAGE=0 (D=4); B: FFT_N=8 STAGE=2 (D=1); C: FFT_N=64 STAGE=1 (D=16)
   logic          a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
   logic [DW-1:0] a_in_re, a_in_im, a_in1_re, a_in1_im, a_in2_re, a_in2_im, a_w_re, a_w_im;
   logic          b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
   logic [DW-1:0] b_in_re, b_in_im, b_in1_re, b_in1_im, b_in2_re, b_in2_im, b_w_re, b_w_im;
   logic          c_rst, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
   logic [DW-1:0] c_in_re, c_in_im, c_in1_re, c_in1_im, c_in2_re, c_in2_im, c_w_re, c_w_im;

   bfly_pair_feeder #(.DATA_W(DW), .FFT_N(8), .STAGE(0)) u_a (
      .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_re(a_in_re), .in_im(a_in_im), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .in1_re(a_in1_re), .in1_im(a_in1_im), .in2_re(a_in2_re), .in2_im(a_in2_im),
      .w_re(a_w_re), .w_im(a_w_im), .out_last(a_out_last)
   );

   bfly_pair_feeder #(.DATA_W(DW), .FFT_N(8), .STAGE(2)) u_b (
      .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_re(b_in_re), .in_im(b_in_im), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .in1_re(b_in1_re), .in1_im(b_in1_im), .in2_re(b_in2_re), .in2_im(b_in2_im),
      .w_re(b_w_re), .w_im(b_w_im), .out_last(b_out_last)
   );

   bfly_pair_feeder #(.DATA_W(DW), .FFT_N(64), .STAGE(1)) u_c (
      .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_re(c_in_re), .in_im(c_in_im), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .in1_re(c_in1_re), .in1_im(c_in1_im), .in2_re(c_in2_re), .in2_im(c_in2_im),
      .w_re(c_w_re), .w_im(c_w_im), .out_last(c_out_last)
   );

   // W(m) for FFT_N=8, m=0..3, Q2.14
   int a_wr[4] = '{16384, 11585, 0, -11585};
   int a_wi[4] = '{0, 11585, 16384, 11585};
   // W(2k) for FFT_N=64, k=0..15, Q2.14
   int c_wr[16] = '{16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196,
                    0, -3196, -6270, -9102, -11585, -13623, -15137, -16069};
   int c_wi[16] = '{0, 3196, 6270, 9102, 11585, 13623, 15137, 16069,
                    16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196};

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Offer one sample to A (im = -re), check in_ready before the edge, advance one cycle.
   task automatic a_step(input logic v, input int re, input logic exp_ready);
      a_in_valid = v;
      a_in_re    = DW'(re);
      a_in_im    = DW'(-re);
      #1;
      chk("a_in_ready", a_in_ready, exp_ready);
      @(posedge clk);
      #1;
   endtask

   task automatic a_chk_pair(input int e1, input int e2, input int ewr, input int ewi,
                             input logic elast);
      chk("a_out_valid", a_out_valid, 1);
      chk("a_in1_re", $signed(a_in1_re), e1);
      chk("a_in1_im", $signed(a_in1_im), -e1);
      chk("a_in2_re", $signed(a_in2_re), e2);
      chk("a_in2_im", $signed(a_in2_im), -e2);
      chk("a_w_re", $signed(a_w_re), ewr);
      chk("a_w_im", $signed(a_w_im), ewi);
      chk("a_out_last", a_out_last, elast);
   endtask

   initial begin
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
      a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
      a_in_re = '0; a_in_im = '0; b_in_re = '0; b_in_im = '0; c_in_re = '0; c_in_im = '0;
      repeat (2) @(posedge clk);
      #1;
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      #1;

      // Reset state
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_last", a_out_last, 0);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_in1_re", a_in1_re, 0);
      chk("rst_in2_im", a_in2_im, 0);
      chk("rst_w_re", a_w_re, 0);
      chk("rst_w_im", a_w_im, 0);

      // Two back-to-back blocks 1..16, out_ready high
      for (int i = 1; i <= 16; i++) begin
         int k;
         a_step(1'b1, i, 1'b1);
         k = (i - 1) % 8;
         if (k >= 4) a_chk_pair(i - 4, i, a_wr[k-4], a_wi[k-4], (k == 7));
         else chk("a_fill_out_valid", a_out_valid, 0);
      end

      // Backpressure on pair (2,6)
      for (int i = 1; i <= 6; i++) a_step(1'b1, i, 1'b1);
      a_chk_pair(2, 6, a_wr[1], a_wi[1], 1'b0);
      a_out_ready = 1'b0;
      repeat (3) begin
         a_step(1'b1, 7, 1'b0);
         a_chk_pair(2, 6, a_wr[1], a_wi[1], 1'b0);
      end
      a_out_ready = 1'b1;
      a_step(1'b1, 7, 1'b1);
      a_chk_pair(3, 7, a_wr[2], a_wi[2], 1'b0);
      a_step(1'b1, 8, 1'b1);
      a_chk_pair(4, 8, a_wr[3], a_wi[3], 1'b1);

      // Next block fills while the last pair stays stalled
      a_out_ready = 1'b0;
      for (int i = 21; i <= 24; i++) begin
         a_step(1'b1, i, 1'b1);
         a_chk_pair(4, 8, a_wr[3], a_wi[3], 1'b1);
      end
      a_step(1'b1, 25, 1'b0);
      a_chk_pair(4, 8, a_wr[3], a_wi[3], 1'b1);
      a_out_ready = 1'b1;
      a_step(1'b0, 0, 1'b1);
      chk("a_drain_out_valid", a_out_valid, 0);

      // Reset after 6 samples, then a clean stream 11..18
      a_rst = 1'b1;
      @(posedge clk);
      #1;
      a_rst = 1'b0;
      for (int i = 1; i <= 6; i++) a_step(1'b1, i, 1'b1);
      a_chk_pair(2, 6, a_wr[1], a_wi[1], 1'b0);
      a_rst      = 1'b1;
      a_in_valid = 1'b0;
      @(posedge clk);
      #1;
      a_rst = 1'b0;
      #1;
      chk("a_midrst_out_valid", a_out_valid, 0);
      chk("a_midrst_out_last", a_out_last, 0);
      chk("a_midrst_in_ready", a_in_ready, 1);
      chk("a_midrst_in1_re", a_in1_re, 0);
      chk("a_midrst_w_im", a_w_im, 0);
      for (int i = 11; i <= 18; i++) begin
         a_step(1'b1, i, 1'b1);
         if (i >= 15) a_chk_pair(i - 4, i, a_wr[i-15], a_wi[i-15], (i == 18));
         else chk("a_refill_out_valid", a_out_valid, 0);
      end
      a_in_valid = 1'b0;

      // D=1: every two samples form a pair, W=(1.0, 0), out_last always set
      for (int i = 1; i <= 8; i++) begin
         b_in_valid = 1'b1;
         b_in_re    = DW'(i);
         b_in_im    = DW'(-i);
         #1;
         chk("b_in_ready", b_in_ready, 1);
         @(posedge clk);
         #1;
         if (i % 2 == 0) begin
            chk("b_out_valid", b_out_valid, 1);
            chk("b_in1_re", $signed(b_in1_re), i - 1);
            chk("b_in1_im", $signed(b_in1_im), 1 - i);
            chk("b_in2_re", $signed(b_in2_re), i);
            chk("b_in2_im", $signed(b_in2_im), -i);
            chk("b_w_re", $signed(b_w_re), 16384);
            chk("b_w_im", $signed(b_w_im), 0);
            chk("b_out_last", b_out_last, 1);
         end else begin
            chk("b_fill_out_valid", b_out_valid, 0);
         end
      end
      b_in_valid = 1'b0;

      // FFT_N=64 STAGE=1: twiddle W(2k) for all 16 pairs
      for (int i = 1; i <= 32; i++) begin
         c_in_valid = 1'b1;
         c_in_re    = DW'(i);
         c_in_im    = DW'(-i);
         #1;
         chk("c_in_ready", c_in_ready, 1);
         @(posedge clk);
         #1;
         if (i >= 17) begin
            chk("c_out_valid", c_out_valid, 1);
            chk("c_w_re", $signed(c_w_re), c_wr[i-17]);
            chk("c_w_im", $signed(c_w_im), c_wi[i-17]);
            chk("c_in1_re", $signed(c_in1_re), i - 16);
            chk("c_in1_im", $signed(c_in1_im), 16 - i);
            chk("c_in2_re", $signed(c_in2_re), i);
            chk("c_in2_im", $signed(c_in2_im), -i);
            chk("c_out_last", c_out_last, (i == 32));
         end
      end
      c_in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
